// File: rtl/move_arbiter_if.sv
// Move event channel between the arbiter and the player engine.
//   move       : one-hot event, meaningful only while move_valid = 1
//   move_valid : event pending
//   move_ready : consumer accepts; a transfer happens on an edge where valid & ready
// Modports: master = arbiter (drives move/move_valid), slave = consumer.
interface move_arbiter_if #(
  parameter int unsigned N = 4
) ();
  logic [N-1:0] move;
  logic         move_valid;
  logic         move_ready;

  modport master (output move, output move_valid, input move_ready);
  modport slave  (input move, input move_valid, output move_ready);
endinterface

// File: rtl/move_arbiter.sv
// move_arbiter: merges active-low debounced buttons and active-high PS/2 key levels into
// one-hot move events with last-pressed-wins arbitration, hold-to-repeat and a one-entry
// event buffer (presses overwrite, repeats are dropped when the buffer is full).
//
// Optional feature macro: MOVE_ARB_REPEAT_EN
//   defined     : hold-to-repeat events and a live drop counter
//   not defined : press events only; drop_cnt tied to 0, repeat parameters ignored
//
// Ports:
//   clk      : logic clock, all state changes on the rising edge
//   rstn     : asynchronous active-low reset
//   btn_n    : [N] debounced buttons, 0 = pressed
//   kbd      : [N] PS/2 key levels, 1 = pressed
//   bus      : move_arbiter_if.master (move, move_valid out; move_ready in)
//   held     : [N] registered merged level
//   drop_cnt : [8] saturating count of repeat events dropped on a full buffer
module move_arbiter #(
  parameter int unsigned N             = 4,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N-1:0]          btn_n,
  input  logic [N-1:0]          kbd,
  move_arbiter_if.master        bus,
  output logic [N-1:0]          held,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

`ifdef MOVE_ARB_REPEAT_EN
  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;
`else
  typedef enum logic [0:0] {StIdle, StDelay} state_e;
`endif

  state_e            r_state;
  logic [N-1:0]      r_s;
  logic [N-1:0]      r_p;
  logic [IdxW-1:0]   r_act;
  logic [N-1:0]      r_move;
  logic              r_valid;

  logic [N-1:0]      w_rise;
  logic              w_cand_vld;
  logic [IdxW-1:0]   w_cand;
  logic              w_s_act;
  logic              w_press;
  logic              w_rpt;
  logic              w_xfer;
  logic [IdxW-1:0]   w_ev_ch;
  logic [N-1:0]      w_ev_onehot;

`ifdef MOVE_ARB_REPEAT_EN
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_drop;
  logic              w_tc;
`else
  logic              w_unused_cfg;
  assign w_unused_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0], CNT_W[0]};
`endif

  assign w_rise  = r_s & ~r_p;
  assign w_s_act = r_s[r_act];
  assign w_xfer  = r_valid & bus.move_ready;

  // Lowest-index rising channel wins; scanning downwards leaves the lowest one last.
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand     = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_cand_vld = 1'b1;
        w_cand     = IdxW'(i);
      end
    end
  end

  // A fresh press is acted on in every state, so it also covers the release edge of the
  // previously active channel.
  always_comb begin
    w_press = w_cand_vld;
`ifdef MOVE_ARB_REPEAT_EN
    w_tc  = (r_state == StDelay) ? (r_cnt == CNT_W'(REPEAT_DELAY - 1))
                                 : (r_cnt == CNT_W'(REPEAT_PERIOD - 1));
    w_rpt = !w_cand_vld && (r_state != StIdle) && w_s_act && w_tc;
`else
    w_rpt = 1'b0;
`endif
    w_ev_ch          = w_press ? w_cand : r_act;
    w_ev_onehot      = '0;
    w_ev_onehot[w_ev_ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_s     <= '0;
      r_p     <= '0;
      r_act   <= '0;
      r_move  <= '0;
      r_valid <= 1'b0;
`ifdef MOVE_ARB_REPEAT_EN
      r_cnt   <= '0;
      r_drop  <= '0;
`endif
    end else begin
      r_s <= kbd | ~btn_n;
      r_p <= r_s;

      unique case (r_state)
        StIdle: begin
          if (w_cand_vld) begin
            r_act   <= w_cand;
            r_state <= StDelay;
`ifdef MOVE_ARB_REPEAT_EN
            r_cnt   <= '0;
`endif
          end
        end
        default: begin
          // A new press restarts the full initial delay even from the repeat phase.
          if (w_cand_vld) begin
            r_act   <= w_cand;
            r_state <= StDelay;
`ifdef MOVE_ARB_REPEAT_EN
            r_cnt   <= '0;
`endif
          end else if (!w_s_act) begin
            r_state <= StIdle;
`ifdef MOVE_ARB_REPEAT_EN
          end else if (w_tc) begin
            r_cnt   <= '0;
            r_state <= StRepeat;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
`endif
          end
        end
      endcase

      // Event buffer: presses always overwrite; a repeat only loads into a free or
      // simultaneously drained slot, otherwise it is counted as dropped.
      if (w_press || (w_rpt && (!r_valid || w_xfer))) begin
        r_move  <= w_ev_onehot;
        r_valid <= 1'b1;
`ifdef MOVE_ARB_REPEAT_EN
      end else if (w_rpt) begin
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
`endif
      end else if (w_xfer) begin
        r_move  <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.move       = r_move;
  assign bus.move_valid = r_valid;
  assign held           = r_s;
`ifdef MOVE_ARB_REPEAT_EN
  assign drop_cnt       = r_drop;
`else
  assign drop_cnt       = 8'd0;
`endif

endmodule
